// File: rtl/f1_start_sequencer.sv
// rtl/f1_start_sequencer.sv - race-start controller driving the 8-light start FSM
module f1_start_sequencer #(
    parameter int TICK_CYCLES = 1000,
    parameter int DELAY_UNIT  = 500,
    parameter int RT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                react,
    output logic                light_en,
    output logic                light_clr,
    output logic                busy,
    output logic                done,
    output logic                jump_start,
    output logic                timeout,
    output logic [RT_WIDTH-1:0] reaction_time
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int UW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT - 1);
    localparam logic [RT_WIDTH-1:0] RT_MAX  = '1;
    localparam logic [RT_WIDTH-1:0] RT_LAST = RT_MAX - RT_WIDTH'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_LIGHTS = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GO     = 3'd4;
    localparam logic [2:0] S_TIMING = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    logic [2:0]          state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [2:0]          lit_q, lit_d;
    logic [UW-1:0]       unit_q, unit_d;
    logic [6:0]          hold_q, hold_d;
    logic [6:0]          lfsr_q, lfsr_d;
    logic [RT_WIDTH-1:0] rt_q, rt_d;
    logic [RT_WIDTH-1:0] rtime_q, rtime_d;
    logic                js_q, js_d;
    logic                to_q, to_d;
    logic                done_q, done_d;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        lit_d     = lit_q;
        unit_d    = unit_q;
        hold_d    = hold_q;
        rt_d      = rt_q;
        rtime_d   = rtime_q;
        js_d      = js_q;
        to_d      = to_q;
        done_d    = 1'b0;
        light_en  = 1'b0;
        light_clr = 1'b0;
        lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[2]};

        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (trigger) state_d = S_ARM;
            end
            S_ARM: begin
                light_clr = 1'b1;
                tick_d    = '0;
                lit_d     = '0;
                unit_d    = '0;
                rt_d      = '0;
                rtime_d   = '0;
                js_d      = 1'b0;
                to_d      = 1'b0;
                state_d   = S_LIGHTS;
            end
            S_LIGHTS: begin
                // An early react wins over a due pulse in the same cycle
                if (react) begin
                    js_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FAULT;
                end else if (tick_q == TICK_LAST) begin
                    light_en = 1'b1;
                    tick_d   = '0;
                    lit_d    = lit_q + 3'd1;
                    if (lit_q == 3'd7) begin
                        hold_d  = lfsr_q;
                        unit_d  = '0;
                        state_d = S_HOLD;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (react) begin
                    js_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FAULT;
                end else if (unit_q == UNIT_LAST) begin
                    unit_d = '0;
                    if (hold_q == 7'd1) state_d = S_GO;
                    else                hold_d  = hold_q - 7'd1;
                end else begin
                    unit_d = unit_q + UW'(1);
                end
            end
            S_GO: begin
                if (react) begin
                    js_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    light_en = 1'b1;
                    rt_d     = '0;
                    state_d  = S_TIMING;
                end
            end
            S_TIMING: begin
                if (react) begin
                    rtime_d = rt_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rt_q == RT_LAST) begin
                    rtime_d = RT_MAX;
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    rt_d = rt_q + RT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            lit_q   <= '0;
            unit_q  <= '0;
            hold_q  <= '0;
            lfsr_q  <= 7'h01;
            rt_q    <= '0;
            rtime_q <= '0;
            js_q    <= 1'b0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            lit_q   <= lit_d;
            unit_q  <= unit_d;
            hold_q  <= hold_d;
            lfsr_q  <= lfsr_d;
            rt_q    <= rt_d;
            rtime_q <= rtime_d;
            js_q    <= js_d;
            to_q    <= to_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q == S_ARM) || (state_q == S_LIGHTS) || (state_q == S_HOLD) ||
                           (state_q == S_GO)  || (state_q == S_TIMING);
    assign done          = done_q;
    assign jump_start    = js_q;
    assign timeout       = to_q;
    assign reaction_time = rtime_q;

endmodule
